// File: rtl/ld_pattern_engine.sv
// LED pattern engine: a prescaled tick steps an LED vector through rotate, fill,
// bounce and invert patterns, with a synchronous load and a tick counter.
module ld_pattern_engine #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pat_in_i,
    output logic [WIDTH-1:0] leds_o,
    output logic             dir_o,
    output logic             step_o,
    output logic [7:0]       steps_o
);

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_ROTL   = 3'd1,
        MODE_ROTR   = 3'd2,
        MODE_FILL   = 3'd3,
        MODE_BOUNCE = 3'd4,
        MODE_INVERT = 3'd5
    } mode_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    dir_e             dir_q, dir_d;
    logic             step_q, step_d;
    logic [7:0]       steps_q, steps_d;

    logic             tick;
    logic [WIDTH-1:0] bnc_leds;
    dir_e             bnc_dir;

    assign tick = en_i && (cnt_q == div_i);

    // Bounce FSM next state; an all-zero pattern reseeds at bit 0 heading left.
    always_comb begin
        bnc_leds = leds_q;
        bnc_dir  = dir_q;
        if (leds_q == '0) begin
            bnc_leds = LED_ONE;
            bnc_dir  = LEFT;
        end else begin
            case (dir_q)
                LEFT: begin
                    if (leds_q[WIDTH-1]) begin
                        bnc_dir  = RIGHT;
                        bnc_leds = leds_q >> 1;
                    end else begin
                        bnc_leds = leds_q << 1;
                    end
                end
                RIGHT: begin
                    if (leds_q[0]) begin
                        bnc_dir  = LEFT;
                        bnc_leds = leds_q << 1;
                    end else begin
                        bnc_leds = leds_q >> 1;
                    end
                end
                default: begin
                    bnc_dir  = LEFT;
                    bnc_leds = leds_q;
                end
            endcase
        end
    end

    // Load wins over tick; a counter above a lowered div wraps naturally to meet it.
    always_comb begin
        cnt_d   = cnt_q;
        leds_d  = leds_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        steps_d = steps_q;
        if (load_i) begin
            cnt_d   = '0;
            leds_d  = pat_in_i;
            dir_d   = LEFT;
            steps_d = '0;
        end else begin
            if (!en_i || tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (tick) begin
                step_d  = 1'b1;
                steps_d = steps_q + 8'd1;
                case (mode_e'(mode_i))
                    MODE_ROTL:   leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                    MODE_ROTR:   leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
                    MODE_FILL:   leds_d = {leds_q[WIDTH-2:0], 1'b1};
                    MODE_BOUNCE: begin
                        leds_d = bnc_leds;
                        dir_d  = bnc_dir;
                    end
                    MODE_INVERT: leds_d = ~leds_q;
                    default:     leds_d = leds_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= '0;
            leds_q  <= '0;
            dir_q   <= LEFT;
            step_q  <= 1'b0;
            steps_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            steps_q <= steps_d;
        end
    end

    assign leds_o  = leds_q;
    assign dir_o   = dir_q;
    assign step_o  = step_q;
    assign steps_o = steps_q;

endmodule

// File: doc/ld_pattern_engine.md
LD_PATTERN_ENGINE -- requirements
Module: ld_pattern_engine

Interface
REQ-001 Parameter WIDTH, default 8: LED vector width (legal range 2..32).
REQ-002 Parameter DIV_W, default 16: prescaler divisor width.
REQ-003 clk  input  1  clock, rising-edge active.
REQ-004 arst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  enables the prescaler and pattern stepping.
REQ-006 mode  input  3  pattern mode, sampled only on a tick.
REQ-007 div  input  DIV_W  prescaler divisor; one tick every div+1 enabled cycles.
REQ-008 load  input  1  synchronous pattern load strobe.
REQ-009 pat_in  input  WIDTH  pattern loaded when load=1.
REQ-010 leds  output  WIDTH  registered LED pattern.
REQ-011 dir  output  1  bounce direction (0 = toward MSB, 1 = toward LSB), registered.
REQ-012 step  output  1  one-cycle pulse marking a pattern update.
REQ-013 steps  output  8  registered count of ticks since the last load or reset, wraps 255->0.

Function
REQ-014 The prescaler counter cnt (DIV_W bits) SHALL hold at 0 while en=0; while en=1 it increments each cycle, and tick is asserted when cnt==div, with cnt returning to 0 on the same edge.
REQ-015 div=0 SHALL produce a tick on every enabled cycle; a change of div mid-count SHALL take effect at the next comparison (if cnt>div, the counter wraps through 2^DIV_W-1 back to 0 with no tick until cnt==div).
REQ-016 load=1 SHALL take priority over tick: on that edge, leds<=pat_in, cnt<=0, dir<=0, steps<=0, and step is 0 in the following cycle, regardless of en.
REQ-017 On a tick without load, leds SHALL update on that edge according to mode:
- 0 HOLD: unchanged.
- 1 ROTL: {leds[W-2:0], leds[W-1]}.
- 2 ROTR: {leds[0], leds[W-1:1]}.
- 3 FILL: {leds[W-2:0], 1'b1}; all ones stays all ones.
- 4 BOUNCE: see REQ-018.
- 5 INVERT: ~leds.
- 6, 7: treated as HOLD.
REQ-018 BOUNCE SHALL be a two-state FSM (LEFT: dir=0, RIGHT: dir=1) evaluated on a tick:
- If leds==0: leds<=1 and dir<=0.
- LEFT with leds[W-1]=1: dir<=1 and leds<=leds>>1.
- LEFT otherwise: leds<=leds<<1.
- RIGHT with leds[0]=1: dir<=0 and leds<=leds<<1.
- RIGHT otherwise: leds<=leds>>1.
- All shifts are zero-fill.
REQ-019 dir SHALL change only in BOUNCE, on load, or on reset; it is retained across other modes.
REQ-020 step SHALL be 1 for exactly the one cycle following each tick edge without load (including HOLD ticks), and 0 otherwise.
REQ-021 steps SHALL increment by 1 on each tick edge without load, modulo 256.
REQ-022 en falling mid-count SHALL clear cnt to 0 on the next edge; the pattern, dir and steps are retained.

Reset
REQ-023 While arst=1, the block SHALL immediately force leds=0, dir=0, step=0, steps=0, cnt=0, independent of clk.
REQ-024 Deassertion of arst SHALL be followed by normal operation from the first rising clk edge, with no spurious step pulse.
REQ-025 arst asserted mid-count or mid-bounce SHALL discard all in-progress state.

Verification
REQ-026 WIDTH=8, div=0, en=1, load pat_in=8'h81, mode=1 -> after 3 ticks leds=8'h0C, step high on each of those cycles, steps=3.
REQ-027 div=3, en=1, mode=2, leds=8'h01 -> leds=8'h80 exactly 4 cycles later; step asserted once, 0 otherwise.
REQ-028 mode=4, leds=8'h40, dir=0, div=0 -> successive leds 8'h80, 8'h40 with dir=1, then 8'h20; after the pattern reaches 8'h01 the next tick gives 8'h02 with dir=0; leds=8'h00 gives 8'h01 on the next tick.
REQ-029 load=1 in the same cycle as a tick in mode 3 -> leds=pat_in, steps=0, no step pulse; mode 3 from 8'h00 -> 8'h01, 8'h03, ..., 8'hFF held.
REQ-030 arst pulsed between clock edges during BOUNCE with leds=8'h10, dir=1, steps=7 -> outputs zero immediately; after release, the first tick gives leds=8'h01 (BOUNCE seed) and steps=1.
REQ-031 en toggled 1->0->1 with div=5 mid-count -> the next tick occurs 6 enabled cycles after re-enable; mode=6 ticks leave leds unchanged but pulse step.
